// File: rtl/turbo_enc_frame_ctrl.sv
// Frame sequencer for the 8-bit turbo encoder datapath.
//
// Loads one frame of K information bits into the datapath frame buffer, then
// drives natural-order (i) and interleaved (pi(i) = (P*i + off) mod K) read
// addresses to the two constituent RSC encoders. It also sequences trellis
// termination and signals frame completion.
//
// Optional feature macro: TURBO_CTRL_PUNCT_EN adds punct_sel for rate-1/2 parity
// alternation. When the macro is undefined the port is absent (rate 1/3).
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   start, abort                    frame start (IDLE only), synchronous abort
//   frame_len, il_step, il_off      K, interleaver multiplier P, offset (latched on start)
//   in_valid / in_ready             input bit handshake (LOAD only)
//   buf_wr_en, buf_wr_addr          frame buffer write port
//   out_ready                       downstream accepts an encoded symbol
//   enc_clr, enc_en, term_en        encoder clear / advance / tail strobes
//   rd_addr_nat, rd_addr_int        natural and interleaved read addresses
//   busy, done, err                 status: not idle, end-of-frame pulse, rejected start
//
// State, addresses and status flags are registered. The strobes buf_wr_en,
// enc_en and term_en are registered phase flags gated by the live handshake
// input, so each strobe lines up with the cycle its handshake completes.
module turbo_enc_frame_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TAIL_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic [ADDR_W-1:0] il_step,
  input  logic [ADDR_W-1:0] il_off,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  input  logic              out_ready,
  output logic              enc_clr,
  output logic              enc_en,
  output logic [ADDR_W-1:0] rd_addr_nat,
  output logic [ADDR_W-1:0] rd_addr_int,
  output logic              term_en,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef TURBO_CTRL_PUNCT_EN
  ,
  output logic              punct_sel
`endif
);

  localparam int unsigned TailW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StEncode, StTail, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   len_q, step_q, off_q;
  logic [ADDR_W-1:0]   wr_cnt_q, nat_q, int_q;
  logic [TailW-1:0]    tail_q;
  logic                in_ready_q, enc_clr_q, busy_q, done_q, err_q;
`ifdef TURBO_CTRL_PUNCT_EN
  logic                punct_q;
`endif

  logic                cfg_ok;
  logic [ADDR_W-1:0]   len_m1;
  logic [ADDR_W:0]     int_sum, int_wrap;
  logic [ADDR_W-1:0]   int_nxt;

  assign cfg_ok = (frame_len >= ADDR_W'(2)) && (il_off < frame_len) &&
                  (il_step != '0) && (il_step < frame_len);
  assign len_m1 = len_q - ADDR_W'(1);

  // Incremental modular step: pi and P are both below K, so one conditional
  // subtraction keeps the sum inside [0, K).
  assign int_sum  = {1'b0, int_q} + {1'b0, step_q};
  assign int_wrap = int_sum - {1'b0, len_q};
  assign int_nxt  = (int_sum >= {1'b0, len_q}) ? int_wrap[ADDR_W-1:0] : int_sum[ADDR_W-1:0];

  assign in_ready    = in_ready_q;
  assign buf_wr_en   = in_valid & in_ready_q;
  assign buf_wr_addr = wr_cnt_q;
  assign enc_clr     = enc_clr_q;
  // The clear cycle is the first ENCODE cycle and never advances the encoders.
  assign enc_en      = (state_q == StEncode) & ~enc_clr_q & out_ready;
  assign term_en     = (state_q == StTail) & out_ready;
  assign rd_addr_nat = nat_q;
  assign rd_addr_int = int_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
`ifdef TURBO_CTRL_PUNCT_EN
  assign punct_sel   = punct_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      step_q     <= '0;
      off_q      <= '0;
      wr_cnt_q   <= '0;
      nat_q      <= '0;
      int_q      <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
      enc_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef TURBO_CTRL_PUNCT_EN
      punct_q    <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      enc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      if (abort) begin
        state_q    <= StIdle;
        wr_cnt_q   <= '0;
        nat_q      <= '0;
        int_q      <= '0;
        tail_q     <= '0;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
`ifdef TURBO_CTRL_PUNCT_EN
        punct_q    <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (cfg_ok) begin
                len_q      <= frame_len;
                step_q     <= il_step;
                off_q      <= il_off;
                wr_cnt_q   <= '0;
                in_ready_q <= 1'b1;
                busy_q     <= 1'b1;
                state_q    <= StLoad;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          StLoad: begin
            if (buf_wr_en) begin
              if (wr_cnt_q == len_m1) begin
                in_ready_q <= 1'b0;
                enc_clr_q  <= 1'b1;
                nat_q      <= '0;
                int_q      <= off_q;
`ifdef TURBO_CTRL_PUNCT_EN
                punct_q    <= 1'b0;
`endif
                state_q    <= StEncode;
              end else begin
                wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
              end
            end
          end
          StEncode: begin
            if (enc_en) begin
`ifdef TURBO_CTRL_PUNCT_EN
              punct_q <= ~punct_q;
`endif
              if (nat_q == len_m1) begin
                // Addresses stay on the last symbol through the tail.
                tail_q  <= '0;
                state_q <= StTail;
              end else begin
                nat_q <= nat_q + ADDR_W'(1);
                int_q <= int_nxt;
              end
            end
          end
          StTail: begin
            if (term_en) begin
`ifdef TURBO_CTRL_PUNCT_EN
              punct_q <= ~punct_q;
`endif
              if (tail_q == TailW'(TAIL_LEN - 1)) begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                tail_q <= tail_q + TailW'(1);
              end
            end
          end
          StDone: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turbo_enc_frame_ctrl.sv
// Self-checking bench for turbo_enc_frame_ctrl. Frames are checked against a
// phase/count model: LOAD takes K accepted bits, one clear cycle, K accepted
// encode cycles with pi(i) = (P*i + off) mod K, TAIL_LEN accepted tail cycles,
// then a single done cycle.
module tb_turbo_enc_frame_ctrl;

  localparam int AW   = 8;
  localparam int TAIL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, in_valid, out_ready;
  logic [AW-1:0] frame_len, il_step, il_off;
  logic          in_ready, buf_wr_en, enc_clr, enc_en, term_en, busy, done, err;
  logic [AW-1:0] buf_wr_addr, rd_addr_nat, rd_addr_int;
`ifdef TURBO_CTRL_PUNCT_EN
  logic          punct_sel;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turbo_enc_frame_ctrl #(.ADDR_W(AW), .TAIL_LEN(TAIL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .frame_len   (frame_len),
    .il_step     (il_step),
    .il_off      (il_off),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .out_ready   (out_ready),
    .enc_clr     (enc_clr),
    .enc_en      (enc_en),
    .rd_addr_nat (rd_addr_nat),
    .rd_addr_int (rd_addr_int),
    .term_en     (term_en),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef TURBO_CTRL_PUNCT_EN
    ,
    .punct_sel   (punct_sel)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All outputs at their idle/reset values.
  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".buf_wr_en"}, buf_wr_en, 0);
    check({tag, ".enc_clr"}, enc_clr, 0);
    check({tag, ".enc_en"}, enc_en, 0);
    check({tag, ".term_en"}, term_en, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".nat"}, rd_addr_nat, 0);
    check({tag, ".int"}, rd_addr_int, 0);
    check({tag, ".wr_addr"}, buf_wr_addr, 0);
  endtask

  // vmode: 0 continuous in_valid, 1 random. rmode: 0 out_ready=1,
  // 1 pattern 1,0,0,1 during encode, 2 random. abort_at >= 0 aborts at that i.
  task automatic run_frame(input int k, input int p, input int off, input int vmode,
                           input int rmode, input int abort_at, input int exp_lat);
    int   phase, n_wr, n_enc, n_tail, lat, rcnt, exp_nat, cnt_en, cnt_term;
    logic ov, orr, ab;
    phase = 0; n_wr = 0; n_enc = 0; n_tail = 0; lat = 1; rcnt = 0;
    cnt_en = 0; cnt_term = 0;
    frame_len = AW'(k); il_step = AW'(p); il_off = AW'(off);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 4 * k + 40; cyc++) begin
      ov = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rmode == 0) orr = 1'b1;
      else if (rmode == 1) orr = (phase != 2) || (rcnt % 4 == 0) || (rcnt % 4 == 3);
      else orr = 1'($urandom_range(0, 1));
      if (phase == 2) rcnt++;
      ab = (abort_at >= 0) && (phase == 2) && (n_enc == abort_at);
      in_valid = ov; out_ready = orr; abort = ab;
      start = (phase == 0) && (n_wr == 1);  // must be ignored outside IDLE
      #1;
      lat++;
      cnt_en += int'(enc_en);
      cnt_term += int'(term_en);
      check("busy", busy, 1);
      check("err", err, 0);
      check("in_ready", in_ready, phase == 0);
      check("buf_wr_en", buf_wr_en, (phase == 0) && ov);
      if (phase == 0) check("buf_wr_addr", buf_wr_addr, n_wr);
      check("enc_clr", enc_clr, phase == 1);
      check("enc_en", enc_en, (phase == 2) && orr);
      check("term_en", term_en, (phase == 3) && orr);
      check("done", done, phase == 4);
      if (phase >= 1 && phase <= 3) begin
        exp_nat = (n_enc < k) ? n_enc : k - 1;
        check("rd_addr_nat", rd_addr_nat, exp_nat);
        check("rd_addr_int", rd_addr_int, (p * exp_nat + off) % k);
      end
`ifdef TURBO_CTRL_PUNCT_EN
      if ((phase == 2 || phase == 3) && orr)
        check("punct_sel", punct_sel, (n_enc + n_tail) % 2);
`endif
      if (ab) begin
        tick();
        abort = 1'b0; start = 1'b0;
        #1;
        check_quiet("abort");
        for (int j = 0; j < 4; j++) begin
          tick();
          check("abort.no_done", done, 0);
          check("abort.busy", busy, 0);
        end
        return;
      end
      if (phase == 4) begin
        if (exp_lat > 0) check("latency", lat, exp_lat);
        check("enc_en_count", cnt_en, k);
        check("term_en_count", cnt_term, TAIL);
        tick();
        start = 1'b0;
        #1;
        check("post.busy", busy, 0);
        check("post.done", done, 0);
        return;
      end
      case (phase)
        0: if (ov) begin n_wr++; if (n_wr == k) phase = 1; end
        1: phase = 2;
        2: if (orr) begin n_enc++; if (n_enc == k) phase = 3; end
        3: if (orr) begin n_tail++; if (n_tail == TAIL) phase = 4; end
        default: ;
      endcase
      tick();
    end
    start = 1'b0;
    check("timeout.phase", phase, 4);
  endtask

  task automatic reject(input string tag, input int k, input int p, input int off);
    frame_len = AW'(k); il_step = AW'(p); il_off = AW'(off);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check({tag, ".err"}, err, 1);
    check({tag, ".busy"}, busy, 0);
    tick();
    check({tag, ".err_clear"}, err, 0);
    check({tag, ".busy2"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, p, off;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    frame_len = '0; il_step = '0; il_off = '0;
    #3;
    check_quiet("reset");
    check("reset.err", err, 0);
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check_quiet("idle");

    // Reference frame, continuous handshakes: latency 1+8+1+8+3+1.
    run_frame(8, 3, 1, 0, 0, -1, 3 + 2 * 8 + TAIL);
    // Same frame with out_ready stalls during encode.
    run_frame(8, 3, 1, 0, 1, -1, 0);

    // Rejected starts.
    reject("rej_len1", 1, 1, 0);
    reject("rej_step0", 8, 0, 1);
    reject("rej_off", 8, 3, 8);
    reject("rej_step", 8, 8, 1);

    // abort together with start in IDLE: frame not started, no err.
    frame_len = 8'd8; il_step = 8'd3; il_off = 8'd1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    check_quiet("abort_start");
    check("abort_start.err", err, 0);
    tick();

    // Abort at i=4.
    run_frame(8, 3, 1, 0, 0, 4, 0);

    // Asynchronous reset in the middle of LOAD.
    frame_len = 8'd6; il_step = 8'd1; il_off = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check_quiet("async_rst");
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check_quiet("after_rst");

    // New K=5 frame completes normally.
    run_frame(5, 2, 3, 0, 0, -1, 3 + 2 * 5 + TAIL);
`ifdef TURBO_CTRL_PUNCT_EN
    run_frame(4, 1, 0, 0, 0, -1, 3 + 2 * 4 + TAIL);
`endif

    // Randomized frames with random handshakes.
    for (int n = 0; n < 6; n++) begin
      k   = int'($urandom_range(2, 30));
      p   = int'($urandom_range(1, k - 1));
      off = int'($urandom_range(0, k - 1));
      run_frame(k, p, off, 1, 2, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
